// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencing controller: default geometry and FSM encoding.
package fir_pkg;

  localparam int TAPS_DEF = 16;
  localparam int AW_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_OUT   = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Handshake and memory-control bundle between the FIR sequencer (master) and its datapath (slave).
interface fir_seq_ctrl_if import fir_pkg::*; #(
  parameter int AW = AW_DEF
);

  logic          in_valid;
  logic          in_ready;
  logic          smp_we;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] coef_addr;
  logic          mac_en;
  logic          mac_clr;
  logic          zero_tap;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  modport master (
    input  in_valid, out_ready,
    output in_ready, smp_we, wr_ptr, rd_addr, coef_addr,
           mac_en, mac_clr, zero_tap, out_valid, busy
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, smp_we, wr_ptr, rd_addr, coef_addr,
           mac_en, mac_clr, zero_tap, out_valid, busy
  );

endinterface

// File: rtl/fir_tap_cnt.sv
// Tap index counter: AW-bit up-counter with synchronous clear (priority) and count enable.
module fir_tap_cnt import fir_pkg::*; #(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [AW-1:0] cnt_o
);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: accepts one sample, walks TAPS delay-line/coefficient addresses, drives the MAC
// strobes one cycle behind the addresses (memory latency), then holds the result until taken.
module fir_seq_ctrl import fir_pkg::*; #(
  parameter int TAPS = TAPS_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  fir_seq_ctrl_if.master bus
);

  localparam logic [AW-1:0] LAST_K   = AW'(TAPS - 1);
  localparam logic [AW:0]   FILL_MAX = (AW + 1)'(TAPS);

  function automatic logic [AW:0] fill_sat_inc(input logic [AW:0] f);
    return (f >= FILL_MAX) ? FILL_MAX : f + (AW + 1)'(1);
  endfunction

  fsm_state_t    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          mac_en_q, mac_en_d;
  logic          mac_clr_q, mac_clr_d;
  logic          zero_tap_q, zero_tap_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          rdy_q;
  logic          in_ready;
  logic          accept;
  logic          cnt_clr;
  logic          cnt_en;
  logic [AW-1:0] k_cnt;

  fir_tap_cnt #(.AW(AW)) u_tap_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (k_cnt)
  );

  // rdy_q keeps in_ready low during reset and until the first clock edge after release.
  assign in_ready = rdy_q & (state_q == ST_IDLE);
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    base_d      = base_q;
    rd_addr_d   = rd_addr_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          base_d    = wr_ptr_q;
          rd_addr_d = wr_ptr_q;
          wr_ptr_d  = wr_ptr_q + AW'(1);
          fill_d    = fill_sat_inc(fill_q);
          cnt_clr   = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_en    = 1'b1;
        rd_addr_d = base_q - (k_cnt + AW'(1));
        if (k_cnt == LAST_K) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // MAC strobes trail the RUN addresses by one cycle to line up with the memory read data.
    mac_en_d   = (state_q == ST_RUN);
    mac_clr_d  = (state_q == ST_RUN) && (k_cnt == '0);
    zero_tap_d = (state_q == ST_RUN) && ({1'b0, k_cnt} >= fill_q);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      base_q      <= '0;
      rd_addr_q   <= '0;
      fill_q      <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      zero_tap_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      base_q      <= base_d;
      rd_addr_q   <= rd_addr_d;
      fill_q      <= fill_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      zero_tap_q  <= zero_tap_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rdy_q       <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.smp_we    = accept;
  assign bus.wr_ptr    = wr_ptr_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.coef_addr = k_cnt;
  assign bus.mac_en    = mac_en_q;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.zero_tap  = zero_tap_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl (TAPS=16): per-scenario tasks plus a scoreboard of expected MAC taps.
module tb_fir_seq_ctrl;

  localparam int TAPS = 16;
  localparam int AW   = 4;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  fir_seq_ctrl_if #(.AW(AW)) bus();

  fir_seq_ctrl #(.TAPS(TAPS), .AW(AW)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0] rd;
    logic [3:0] coef;
    logic       clr;
    logic       zero;
  } tap_t;

  tap_t       sb_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [3:0] m_wr;
  logic [4:0] m_fill;
  logic [3:0] rd_prev;
  logic [3:0] coef_prev;

  // Each MAC cycle consumes the addresses presented one cycle earlier.
  always @(negedge clk) begin
    tap_t exp_t;
    tap_t act_t;
    if (bus.mac_en === 1'b1) begin
      act_t.rd   = rd_prev;
      act_t.coef = coef_prev;
      act_t.clr  = bus.mac_clr;
      act_t.zero = bus.zero_tap;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underflow: mac_en high, got tap=%h, required no tap", act_t);
      end else begin
        exp_t = sb_q.pop_front();
        if (act_t !== exp_t)
          begin
            miscompares++;
            $display("FAIL sb_tap: got rd=%0d coef=%0d clr=%b zero=%b, required rd=%0d coef=%0d clr=%b zero=%b",
                     act_t.rd, act_t.coef, act_t.clr, act_t.zero, exp_t.rd, exp_t.coef, exp_t.clr, exp_t.zero);
          end
      end
    end
    rd_prev   = bus.rd_addr;
    coef_prev = bus.coef_addr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sb_push(input logic [3:0] base, input logic [4:0] fill);
    for (int k = 0; k < TAPS; k++) begin
      tap_t t;
      t.rd   = base - 4'(k);
      t.coef = 4'(k);
      t.clr  = (k == 0);
      t.zero = (k >= int'(fill));
      sb_q.push_back(t);
    end
  endtask

  // Drives one accepted sample; returns in cycle 1 (just after the accept edge).
  task automatic accept_one(output int ok);
    int n;
    ok = 0;
    @(negedge clk);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_wait: in_ready=%b, required 1", bus.in_ready);
      return;
    end
    bus.in_valid = 1'b1;
    #1;
    vectors++;
    if (bus.smp_we !== 1'b1 || bus.wr_ptr !== m_wr) begin
      miscompares++;
      $display("FAIL accept_strobe: smp_we=%b wr_ptr=%0d, required 1 / %0d", bus.smp_we, bus.wr_ptr, m_wr);
    end
    m_fill = (m_fill >= 5'd16) ? 5'd16 : m_fill + 5'd1;
    sb_push(m_wr, m_fill);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    m_wr = m_wr + 4'd1;
    vectors++;
    if (bus.wr_ptr !== m_wr) begin
      miscompares++;
      $display("FAIL wr_ptr_advance: got %0d, required %0d", bus.wr_ptr, m_wr);
    end
    ok = 1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_wait: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_reset();
    rstn          = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    m_wr          = '0;
    m_fill        = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.in_ready, bus.smp_we, bus.busy, bus.out_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: in_ready/smp_we/busy/out_valid=%b, required 0000",
               {bus.in_ready, bus.smp_we, bus.busy, bus.out_valid});
    end
    vectors++;
    if ({bus.mac_en, bus.mac_clr, bus.zero_tap, bus.wr_ptr} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_mac: mac_en/clr/zero/wr_ptr=%b, required 0", {bus.mac_en, bus.mac_clr, bus.zero_tap, bus.wr_ptr});
    end
    bus.in_valid = 1'b0;
    rstn = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_pre_edge: in_ready=%b, required 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_first_edge: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    int ok;
    int zero_cnt;
    logic [4:0] exp_v;
    logic [4:0] act_v;
    zero_cnt = 0;
    accept_one(ok);
    if (ok == 0) return;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      exp_v = {(c >= 2 && c <= 17), (c == 2), (c == 18), (c <= 18), (c >= 19)};
      act_v = {bus.mac_en, bus.mac_clr, bus.out_valid, bus.busy, bus.in_ready};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL single_timeline c=%0d: en/clr/ov/busy/rdy=%b, required %b", c, act_v, exp_v);
      end
      if (bus.zero_tap === 1'b1) zero_cnt++;
    end
    vectors++;
    if (zero_cnt != 15) begin
      miscompares++;
      $display("FAIL single_zero_count: got %0d, required 15", zero_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int accepts;
    int last;
    int cyc;
    int wrap_seen;
    logic prev_was_15;
    accepts     = 0;
    last        = -1;
    cyc         = 0;
    wrap_seen   = 0;
    prev_was_15 = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    while (accepts < 16 && cyc < 16 * 19 + 40) begin
      #1;
      if (bus.smp_we === 1'b1) begin
        vectors++;
        if (bus.wr_ptr !== m_wr) begin
          miscompares++;
          $display("FAIL b2b_wr_ptr: got %0d, required %0d", bus.wr_ptr, m_wr);
        end
        if (prev_was_15 && bus.wr_ptr === 4'd0) wrap_seen = 1;
        prev_was_15 = (bus.wr_ptr === 4'd15);
        if (last >= 0) begin
          vectors++;
          if (cyc - last != 19) begin
            miscompares++;
            $display("FAIL b2b_interval: got %0d cycles, required 19", cyc - last);
          end
        end
        last   = cyc;
        m_fill = (m_fill >= 5'd16) ? 5'd16 : m_fill + 5'd1;
        sb_push(m_wr, m_fill);
        m_wr = m_wr + 4'd1;
        accepts++;
      end
      if (accepts < 16) begin
        @(negedge clk);
        cyc++;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    vectors++;
    if (accepts != 16) begin
      miscompares++;
      $display("FAIL b2b_accepts: got %0d, required 16", accepts);
    end
    vectors++;
    if (wrap_seen != 1) begin
      miscompares++;
      $display("FAIL b2b_wrap: wr_ptr 15->0 seen=%0d, required 1", wrap_seen);
    end
    wait_idle();
  endtask

  task automatic test_rd_addr();
    int ok;
    logic [3:0] exp_rd;
    for (int i = 0; i < 2; i++) begin
      accept_one(ok);
      wait_idle();
    end
    accept_one(ok);
    if (ok == 0) return;
    vectors++;
    if (bus.wr_ptr !== 4'd4) begin
      miscompares++;
      $display("FAIL rd_wr_ptr_after: got %0d, required 4", bus.wr_ptr);
    end
    for (int c = 1; c <= TAPS; c++) begin
      @(negedge clk);
      exp_rd = 4'd3 - 4'(c - 1);
      vectors++;
      if (bus.rd_addr !== exp_rd || bus.coef_addr !== 4'(c - 1)) begin
        miscompares++;
        $display("FAIL rd_seq c=%0d: rd=%0d coef=%0d, required %0d / %0d", c, bus.rd_addr, bus.coef_addr, exp_rd, c - 1);
      end
    end
    wait_idle();
  endtask

  task automatic test_out_stall();
    int ok;
    int n;
    logic [3:0] rd0;
    logic [3:0] coef0;
    logic [3:0] wr0;
    bus.out_ready = 1'b0;
    accept_one(ok);
    if (ok == 0) return;
    n = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_out_valid_wait: out_valid=%b, required 1", bus.out_valid);
    end
    rd0   = bus.rd_addr;
    coef0 = bus.coef_addr;
    wr0   = bus.wr_ptr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.out_valid, bus.in_ready, bus.busy, bus.mac_en} !== 4'b1010 ||
          bus.rd_addr !== rd0 || bus.coef_addr !== coef0 || bus.wr_ptr !== wr0) begin
        miscompares++;
        $display("FAIL stall_hold i=%0d: ov/rdy/busy/en=%b rd=%0d coef=%0d wr=%0d, required 1010 %0d %0d %0d",
                 i, {bus.out_valid, bus.in_ready, bus.busy, bus.mac_en}, bus.rd_addr, bus.coef_addr, bus.wr_ptr,
                 rd0, coef0, wr0);
      end
      if (i == 4) begin
        bus.in_valid = 1'b1;
        #1;
        vectors++;
        if (bus.smp_we !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_ignore_we: smp_we=%b, required 0", bus.smp_we);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.wr_ptr !== wr0) begin
          miscompares++;
          $display("FAIL stall_ignore_ptr: wr_ptr=%0d, required %0d", bus.wr_ptr, wr0);
        end
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL stall_release: ov/rdy=%b, required 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_reset_mid_run();
    int ok;
    int zero_cnt;
    int ov_seen;
    bus.out_ready = 1'b1;
    accept_one(ok);
    if (ok == 0) return;
    repeat (8) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1 || bus.mac_en !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_pre: busy/mac_en=%b%b, required 11", bus.busy, bus.mac_en);
    end
    #2;
    rstn = 1'b0;
    sb_q.delete();
    #1;
    vectors++;
    if ({bus.mac_en, bus.mac_clr, bus.zero_tap, bus.out_valid, bus.busy, bus.in_ready, bus.smp_we} !== 7'd0 ||
        bus.wr_ptr !== 4'd0 || bus.rd_addr !== 4'd0 || bus.coef_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL midrun_async: ctl=%b wr=%0d rd=%0d coef=%0d, required all 0",
               {bus.mac_en, bus.mac_clr, bus.zero_tap, bus.out_valid, bus.busy, bus.in_ready, bus.smp_we},
               bus.wr_ptr, bus.rd_addr, bus.coef_addr);
    end
    repeat (2) @(negedge clk);
    rstn   = 1'b1;
    m_wr   = '0;
    m_fill = '0;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.wr_ptr !== 4'd0) begin
      miscompares++;
      $display("FAIL midrun_release: in_ready=%b wr_ptr=%0d, required 1 / 0", bus.in_ready, bus.wr_ptr);
    end
    ov_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) ov_seen++;
    end
    vectors++;
    if (ov_seen != 0) begin
      miscompares++;
      $display("FAIL midrun_no_out: out_valid/busy cycles=%0d, required 0", ov_seen);
    end
    zero_cnt = 0;
    accept_one(ok);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.zero_tap === 1'b1) zero_cnt++;
    end
    vectors++;
    if (zero_cnt != 15) begin
      miscompares++;
      $display("FAIL midrun_fill_cleared: zero_tap count=%0d, required 15", zero_cnt);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rd_addr();
    test_out_stall();
    test_reset_mid_run();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d taps never seen, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
